// File: rtl/shift_tx_arbiter.sv
// shift_tx_arbiter: round-robin arbiter between two requesters sharing one
// WIDTH-bit left-shift register; each granted word is shifted out MSB-first
// with a valid strobe and followed by a one-cycle done pulse.
module shift_tx_arbiter #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             owner,
    output logic             busy,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_gnt_a;
    logic             r_gnt_b;
    logic             r_owner;
    logic             r_last_owner;
    logic             w_grant;
    logic             w_win_b;
    logic             w_last_bit;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration, next-state selection and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_win_b     = 1'b0;
        w_last_bit  = 1'b0;
        busy        = 1'b0;
        ser_valid   = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant = req_a | req_b;
                // B wins alone, or on a tie when A owned the last transfer
                w_win_b = req_b & (~req_a | ~r_last_owner);
                if (w_grant) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy       = 1'b1;
                ser_valid  = 1'b1;
                w_last_bit = (r_cnt == CNT_W'(WIDTH - 1));
                if (w_last_bit) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Shift register, bit counter, grant pulses and ownership tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q          <= '0;
            r_cnt        <= '0;
            r_gnt_a      <= 1'b0;
            r_gnt_b      <= 1'b0;
            r_owner      <= 1'b1;
            r_last_owner <= 1'b1;
        end else begin
            r_gnt_a <= w_grant & ~w_win_b;
            r_gnt_b <= w_grant & w_win_b;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_q     <= w_win_b ? data_b : data_a;
                        r_cnt   <= '0;
                        r_owner <= w_win_b;
                    end
                end
                S_SHIFT: begin
                    r_q   <= {r_q[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last_bit) begin
                        r_last_owner <= r_owner;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign gnt_a   = r_gnt_a;
    assign gnt_b   = r_gnt_b;
    assign owner   = r_owner;
    assign q       = r_q;
    assign ser_out = r_q[WIDTH-1];

endmodule

// File: tb/tb_shift_tx_arbiter.sv
// Bench for shift_tx_arbiter: transfer-level reference model, directed
// scenarios with literal expectations, then randomized traffic and resets.
module tb_shift_tx_arbiter;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_a = 1'b0;
    logic [W-1:0] data_a = '0;
    logic         req_b = 1'b0;
    logic [W-1:0] data_b = '0;
    logic         gnt_a, gnt_b, owner, busy, ser_out, ser_valid, done;
    logic [W-1:0] q;

    int n_tests = 0;
    int n_fail  = 0;

    shift_tx_arbiter #(.WIDTH(W), .CNT_W(3)) dut (
        .clk(clk), .reset(rst_n),
        .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .owner(owner), .busy(busy), .q(q),
        .ser_out(ser_out), .ser_valid(ser_valid), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: a transfer occupies W bit cycles plus one done cycle.
    // m_left counts the cycles of the transfer still to be shown (0 = idle).
    int           m_left = 0;
    logic [W-1:0] m_word = '0;
    logic         m_owner = 1'b1;
    logic         m_last = 1'b1;
    logic         m_ga = 1'b0;
    logic         m_gb = 1'b0;

    function automatic logic pick_b(input logic ra, input logic rb, input logic last);
        if (ra && rb) return ~last;
        return rb;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  <= 0;
            m_word  <= '0;
            m_owner <= 1'b1;
            m_last  <= 1'b1;
            m_ga    <= 1'b0;
            m_gb    <= 1'b0;
        end else begin
            m_ga <= 1'b0;
            m_gb <= 1'b0;
            if (m_left == 0) begin
                if (req_a || req_b) begin
                    m_left  <= W + 1;
                    m_word  <= pick_b(req_a, req_b, m_last) ? data_b : data_a;
                    m_owner <= pick_b(req_a, req_b, m_last);
                    m_last  <= pick_b(req_a, req_b, m_last);
                    m_ga    <= ~pick_b(req_a, req_b, m_last);
                    m_gb    <= pick_b(req_a, req_b, m_last);
                end
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [W-1:0] eq;
        eq = (m_left >= 2) ? (m_word << (W + 1 - m_left)) : '0;
        chk("q",         32'(q),         32'(eq));
        chk("ser_out",   32'(ser_out),   32'(eq[W-1]));
        chk("ser_valid", 32'(ser_valid), 32'(m_left >= 2));
        chk("done",      32'(done),      32'(m_left == 1));
        chk("busy",      32'(busy),      32'(m_left != 0));
        chk("gnt_a",     32'(gnt_a),     32'(m_ga));
        chk("gnt_b",     32'(gnt_b),     32'(m_gb));
        chk("owner",     32'(owner),     32'(m_owner));
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic go_idle();
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (12) step();
    endtask

    // Assert reset between edges and check outputs clear without a clock
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 compare_all();
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] bits;
        int           g_who[$];
        int           g_cyc[$];

        // 1: reset held with random inputs
        repeat (4) begin
            req_a = 1'($urandom); req_b = 1'($urandom);
            data_a = W'($urandom); data_b = W'($urandom);
            step();
        end
        chk("t1_q", 32'(q), 32'd0);
        chk("t1_owner", 32'(owner), 32'd1);
        chk("t1_valid", 32'(ser_valid), 32'd0);
        req_a = 1'b0; req_b = 1'b0;
        rst_n = 1'b1;
        step();
        chk("t1_busy", 32'(busy), 32'd0);

        // 2: single A transfer
        req_a = 1'b1; data_a = 6'b101101;
        step();
        chk("t2_gnt_a", 32'(gnt_a), 32'd1);
        chk("t2_owner", 32'(owner), 32'd0);
        req_a = 1'b0;
        bits[5] = ser_out;
        for (int i = 1; i < W; i++) begin
            step();
            bits[5-i] = ser_out;
        end
        chk("t2_bits", 32'(bits), 32'b101101);
        step();
        chk("t2_done", 32'(done), 32'd1);
        step();
        chk("t2_busy_low", 32'(busy), 32'd0);

        // 3: tie after reset, A first, then held B
        async_reset();
        step();
        rst_n = 1'b1;
        req_a = 1'b1; data_a = 6'b111000;
        req_b = 1'b1; data_b = 6'b000111;
        step();
        chk("t3_gnt_a", 32'(gnt_a), 32'd1);
        chk("t3_gnt_b0", 32'(gnt_b), 32'd0);
        req_a = 1'b0;
        bits[5] = ser_out;
        for (int i = 1; i < W; i++) begin
            step();
            bits[5-i] = ser_out;
        end
        chk("t3_bits_a", 32'(bits), 32'b111000);
        step();
        chk("t3_done_a", 32'(done), 32'd1);
        step();
        chk("t3_idle_nognt", 32'(gnt_b), 32'd0);
        step();
        chk("t3_gnt_b", 32'(gnt_b), 32'd1);
        chk("t3_owner_b", 32'(owner), 32'd1);
        req_b = 1'b0;
        bits[5] = ser_out;
        for (int i = 1; i < W; i++) begin
            step();
            bits[5-i] = ser_out;
        end
        chk("t3_bits_b", 32'(bits), 32'b000111);

        // 4: continuous dual requests alternate
        go_idle();
        req_a = 1'b1; data_a = 6'b010011;
        req_b = 1'b1; data_b = 6'b100110;
        for (int c = 1; c <= 32; c++) begin
            step();
            if (gnt_a || gnt_b) begin
                g_who.push_back(gnt_b ? 1 : 0);
                g_cyc.push_back(c);
            end
        end
        chk("t4_count", 32'(g_who.size()), 32'd4);
        if (g_who.size() == 4) begin
            chk("t4_g0", 32'(g_who[0]), 32'd0);
            chk("t4_g1", 32'(g_who[1]), 32'd1);
            chk("t4_g2", 32'(g_who[2]), 32'd0);
            chk("t4_g3", 32'(g_who[3]), 32'd1);
            chk("t4_gap", 32'(g_cyc[3] - g_cyc[0]), 32'd24);
            chk("t4_first", 32'(g_cyc[0]), 32'd1);
        end

        // 5: B request arriving mid-transfer waits for IDLE
        go_idle();
        req_a = 1'b1; data_a = 6'b110101;
        step();
        chk("t5_gnt_a", 32'(gnt_a), 32'd1);
        req_a = 1'b0;
        step();
        step();
        req_b = 1'b1; data_b = 6'b011001;
        for (int c = 4; c <= 8; c++) begin
            step();
            chk("t5_no_gnt_b", 32'(gnt_b), 32'd0);
        end
        step();
        chk("t5_gnt_b", 32'(gnt_b), 32'd1);
        req_b = 1'b0;

        // 6: reset during B's bit 4, then a tie goes to A
        go_idle();
        req_b = 1'b1; data_b = 6'b110011;
        step();
        chk("t6_gnt_b", 32'(gnt_b), 32'd1);
        req_b = 1'b0;
        step(); step(); step();
        async_reset();
        req_a = 1'b1; data_a = 6'b001110;
        req_b = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        chk("t6_gnt_a", 32'(gnt_a), 32'd1);
        chk("t6_q", 32'(q), 32'b001110);
        req_a = 1'b0;

        // Randomized traffic with occasional asynchronous resets
        for (int c = 0; c < 1500; c++) begin
            step();
            if (!rst_n) begin
                rst_n = 1'b1;
            end
            if (req_a && m_ga) req_a = 1'b0;
            else if (!req_a && $urandom_range(0, 3) == 0) begin
                req_a = 1'b1;
                data_a = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
            end
            if (req_b && m_gb) req_b = 1'b0;
            else if (!req_b && $urandom_range(0, 3) == 0) begin
                req_b = 1'b1;
                data_b = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
            end
            if ($urandom_range(0, 79) == 0) async_reset();
        end
        rst_n = 1'b1;
        go_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
